// File: rtl/axi_defs.sv
// Shared AXI3 constants and FSM encodings for the sram-like to AXI bridge.
package axi_defs;

  localparam logic [3:0] AXI_ID_INST = 4'd0;
  localparam logic [3:0] AXI_ID_DATA = 4'd1;

  // Single-beat, non-cacheable, unprivileged transfers only.
  localparam logic [3:0] AXI_LEN        = 4'd0;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_LOCK       = 2'b00;
  localparam logic [3:0] AXI_CACHE      = 4'd0;
  localparam logic [2:0] AXI_PROT       = 3'd0;
  localparam logic [3:0] AXI_WID        = AXI_ID_DATA;
  localparam logic       AXI_WLAST      = 1'b1;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_AR   = 2'd1,
    R_R    = 2'd2
  } rd_state_e;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_REQ  = 2'd1,
    W_B    = 2'd2
  } wr_state_e;

endpackage

// File: rtl/axi_sram_bridge.sv
// Bridges the core's instruction and data sram-like ports onto one AXI3 master.
//   state  | meaning
//   R_IDLE | no read outstanding, may accept a data or inst read
//   R_AR   | arvalid held until arready
//   R_R    | rready high, waiting for the single read beat
//   W_IDLE | no write outstanding
//   W_REQ  | aw and w channels presented, each dropping on its own handshake
//   W_B    | bready high, waiting for the write response
module axi_sram_bridge
  import axi_defs::*;
#(
  parameter logic [3:0] ID_INST = AXI_ID_INST,
  parameter logic [3:0] ID_DATA = AXI_ID_DATA
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [2:0]  arsize,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic        rvalid,
  output logic        rready,
  output logic [31:0] awaddr,
  output logic [2:0]  awsize,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  input  logic        bvalid,
  output logic        bready
);

  rd_state_e   r_state_q, r_state_d;
  wr_state_e   w_state_q, w_state_d;
  logic [31:0] araddr_q, araddr_d;
  logic [1:0]  arsize_q, arsize_d;
  logic [3:0]  arid_q, arid_d;
  logic [31:0] awaddr_q, awaddr_d;
  logic [1:0]  awsize_q, awsize_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;

  logic rd_holds_data, data_rd_go, data_wr_go, inst_go, r_hit, b_hit;

  // Accepts are gated by resetn so nothing is handshaken during a reset cycle.
  always_comb begin
    rd_holds_data = (r_state_q != R_IDLE) && (arid_q == ID_DATA);
    data_rd_go    = resetn && (r_state_q == R_IDLE) && (w_state_q == W_IDLE)
                    && data_req && !data_wr;
    inst_go       = resetn && (r_state_q == R_IDLE) && inst_req && !data_rd_go;
    data_wr_go    = resetn && (w_state_q == W_IDLE) && data_req && data_wr
                    && !rd_holds_data;
  end

  always_comb begin
    r_state_d = r_state_q;
    araddr_d  = araddr_q;
    arsize_d  = arsize_q;
    arid_d    = arid_q;
    arvalid   = 1'b0;
    rready    = 1'b0;
    r_hit     = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        if (data_rd_go) begin
          araddr_d  = data_addr;
          arsize_d  = data_size;
          arid_d    = ID_DATA;
          r_state_d = R_AR;
        end else if (inst_go) begin
          araddr_d  = inst_addr;
          arsize_d  = 2'd2;
          arid_d    = ID_INST;
          r_state_d = R_AR;
        end
      end
      R_AR: begin
        arvalid = 1'b1;
        if (arready) r_state_d = R_R;
      end
      R_R: begin
        rready = 1'b1;
        if (rvalid) begin
          // A beat with a foreign rid is consumed but never reported.
          r_hit     = resetn && (rid == arid_q);
          r_state_d = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    w_state_d = w_state_q;
    awaddr_d  = awaddr_q;
    awsize_d  = awsize_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    awvalid   = 1'b0;
    wvalid    = 1'b0;
    bready    = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (data_wr_go) begin
          awaddr_d  = data_addr;
          awsize_d  = data_size;
          wdata_d   = data_wdata;
          wstrb_d   = data_wstrb;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          w_state_d = W_REQ;
        end
      end
      W_REQ: begin
        awvalid   = !aw_done_q;
        wvalid    = !w_done_q;
        aw_done_d = aw_done_q || awready;
        w_done_d  = w_done_q || wready;
        if (aw_done_d && w_done_d) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          w_state_d = W_B;
        end
      end
      W_B: begin
        bready = 1'b1;
        if (bvalid) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  assign b_hit = resetn && (w_state_q == W_B) && bvalid;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state_q <= R_IDLE;
      w_state_q <= W_IDLE;
      araddr_q  <= '0;
      arsize_q  <= '0;
      arid_q    <= '0;
      awaddr_q  <= '0;
      awsize_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      w_state_q <= w_state_d;
      araddr_q  <= araddr_d;
      arsize_q  <= arsize_d;
      arid_q    <= arid_d;
      awaddr_q  <= awaddr_d;
      awsize_q  <= awsize_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  assign inst_addr_ok = inst_go;
  assign data_addr_ok = data_rd_go || data_wr_go;
  assign inst_data_ok = r_hit && (arid_q == ID_INST);
  assign data_data_ok = (r_hit && (arid_q == ID_DATA)) || b_hit;
  assign inst_rdata   = rdata;
  assign data_rdata   = rdata;

  assign arid   = arid_q;
  assign araddr = araddr_q;
  assign arsize = {1'b0, arsize_q};
  assign awaddr = awaddr_q;
  assign awsize = {1'b0, awsize_q};
  assign wdata  = wdata_q;
  assign wstrb  = wstrb_q;

endmodule
